tl_ul_regbus_bridge: RTL and testbench
======================================

Name: tl_ul_regbus_bridge

Overview:
- TileLink-UL slave terminating the fragmenter+buffer pair; consumes the single-beat A requests that pair produces.
- Converts each request into one access on a simple register bus (req/ack, variable latency).
- Returns exactly one D response per A request. Non-pipelined: one outstanding transaction, so it suits low-rate peripheral register banks.

Parameters:
- ADDR_W, 32, A-channel address width
- DATA_W, 32, data width; mask width = DATA_W/8
- SIZE_W, 2, a_size/d_size width
- SRC_W, 2, a_source/d_source width
- TIMEOUT, 255, cycles without rb_ack before the access is abandoned; 0 disables the timeout

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get, others illegal
- a_param  in  3  ignored
- a_size  in  SIZE_W  log2 bytes
- a_source  in  SRC_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  DATA_W/8  byte lanes
- a_data  in  DATA_W  write data
- a_corrupt  in  1  write data poisoned
- d_valid  out  1  response valid
- d_ready  in  1  response taken
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SIZE_W  echo of a_size
- d_source  out  SRC_W  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  error response
- d_data  out  DATA_W  read data
- d_corrupt  out  1  read data invalid
- rb_req  out  1  register access request
- rb_we  out  1  1=write
- rb_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero)
- rb_wdata  out  DATA_W  write data
- rb_wmask  out  DATA_W/8  byte enables
- rb_ack  in  1  access complete
- rb_rdata  in  DATA_W  read data, valid with rb_ack
- rb_err  in  1  access error, valid with rb_ack
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0, including a_ready while reset is high; timeout counter 0. Reset mid-transaction abandons it: rb_req and d_valid are 0 the cycle after reset is sampled, and no response is issued.
- IDLE:
  - a_ready=1.
  - On a_valid, latch opcode, size, source, address, mask, data.
  - Legal = opcode in {0,1,4}, 2**a_size <= DATA_W/8, and address aligned to size.
  - Legal and not (Put with a_corrupt=1): go to BUS.
  - Otherwise: go to RESP with denied=1 and no bus access.
- BUS:
  - rb_req=1 with rb_* stable until rb_ack.
  - rb_we = opcode!=4. rb_wmask = a_mask for Put, all ones for Get.
  - Counter increments each cycle rb_req=1 && !rb_ack.
  - rb_ack: capture rb_rdata and rb_err into the response regs; rb_req drops the next cycle; go to RESP.
  - Timeout (counter==TIMEOUT, TIMEOUT!=0): go to RESP with denied=1 and data 0. A late rb_ack after a timeout is ignored.
- RESP:
  - d_valid=1 with all d_* held stable until d_ready.
  - d_opcode = 1 for Get, 0 for Put.
  - d_denied = stored error.
  - d_corrupt = d_denied && Get.
  - d_data = captured rdata for a non-denied Get, else 0.
  - On d_valid && d_ready go to IDLE. a_ready stays 0, so there is no back-to-back acceptance in that cycle.
- Latency: A fire at cycle 0 → rb_req at cycle 1. rb_ack at cycle n → d_valid at cycle n+1. Minimum is 3 cycles per transaction for a zero-wait slave (ack in cycle 1).
- Error path: an illegal A fire at cycle 0 gives d_valid at cycle 1.
- rb_ack while rb_req=0 is ignored.
- rb_err takes effect only when sampled together with rb_ack.

Decomposition:
- Shared TL package: A/D opcode constants, state enum {IDLE, BUS, RESP}, response struct {opcode, size, source, denied, data}.
- Sub-module tl_ul_legal_check: combinational opcode/size/alignment check returning legal. It is reused by other UL slaves.

Test Plan:
- Get addr 0x10, size 2, source 1; rb_ack after 2 wait cycles with rdata 0xDEADBEEF → d_opcode=1, d_data=0xDEADBEEF, d_source=1, d_denied=0; d_valid 1 cycle after ack.
- PutPartial addr 0x6, size 1, mask 0xC, data 0xAABB0000 → rb_we=1, rb_addr=0x4, rb_wmask=0xC; ack → d_opcode=0, d_denied=0.
- Illegal opcode 2 (arithmetic) → rb_req never asserts; d_valid next cycle, d_denied=1, d_corrupt=0.
- Get with rb_ack+rb_err → d_denied=1, d_corrupt=1, d_data=0. Separately, TIMEOUT=4 with no ack → d_denied=1 after 4 stalled cycles, and a later rb_ack does not create a second response.
- d_ready held low 5 cycles → d_* stable and a_ready=0 throughout; on release, busy=0 and a_ready=1 the next cycle.
- Reset asserted during BUS → rb_req=0 and d_valid=0 the next cycle; after release a new Get completes normally.

Source files
------------

// File: rtl/tl_ul_regbus_bridge_pkg.sv
// Shared TileLink-UL definitions used by the UL slave blocks:
// A/D channel opcode constants, the bridge state encoding and the
// stored-response flags.
package tl_ul_regbus_bridge_pkg;

    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] A_GET             = 3'd4;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width-independent part of the pending D response; size, source and
    // data are held in parameter-sized registers in the bridge itself.
    typedef struct packed {
        logic [2:0] opcode;
        logic       denied;
    } resp_t;

endpackage

// File: rtl/tl_ul_legal_check.sv
// Combinational TL-UL A-request legality check.
//   opcode  : A-channel opcode
//   size    : log2 of the access size in bytes
//   address : byte address
//   legal   : 1 when opcode is Get/PutFull/PutPartial, the access fits in
//             one data beat and the address is aligned to the access size
module tl_ul_legal_check
    import tl_ul_regbus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SIZE_W = 2
) (
    input  logic [2:0]        opcode,
    input  logic [SIZE_W-1:0] size,
    input  logic [ADDR_W-1:0] address,
    output logic              legal
);

    localparam int unsigned LG_BYTES = $clog2(DATA_W / 8);

    logic op_ok;
    logic size_ok;
    logic aligned;
    logic unused_address;

    // Only the low address bits take part in the alignment test.
    assign unused_address = ^address;

    always_comb begin
        op_ok   = (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL) || (opcode == A_GET);
        size_ok = (32'(size) <= LG_BYTES);
        aligned = 1'b1;
        for (int unsigned i = 0; i < LG_BYTES; i++) begin
            if ((i < 32'(size)) && address[i]) begin
                aligned = 1'b0;
            end
        end
        legal = op_ok && size_ok && aligned;
    end

endmodule

// File: rtl/tl_ul_regbus_bridge.sv
// TileLink-UL slave to simple req/ack register bus bridge, one outstanding
// transaction at a time.
//   clock, reset       : clock, synchronous active-high reset
//   a_*                : TL-UL A channel (single-beat requests)
//   d_*                : TL-UL D channel (one response per request)
//   rb_*               : register bus; rb_req held with stable rb_* until rb_ack
//   busy               : a transaction is in progress
module tl_ul_regbus_bridge
    import tl_ul_regbus_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SIZE_W  = 2,
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_corrupt,
    output logic                rb_req,
    output logic                rb_we,
    output logic [ADDR_W-1:0]   rb_addr,
    output logic [DATA_W-1:0]   rb_wdata,
    output logic [DATA_W/8-1:0] rb_wmask,
    input  logic                rb_ack,
    input  logic [DATA_W-1:0]   rb_rdata,
    input  logic                rb_err,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(MASK_W - 1);

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [SIZE_W-1:0]   size_q;
    logic [SRC_W-1:0]    source_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [MASK_W-1:0]   mask_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt_q;
    resp_t               resp_q;

    logic legal;
    logic go_bus;
    logic timeout_hit;
    logic is_get;
    logic unused_a_param;

    assign unused_a_param = ^a_param;

    tl_ul_legal_check #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_legal (
        .opcode  (a_opcode),
        .size    (a_size),
        .address (a_address),
        .legal   (legal)
    );

    // A legal request still skips the bus if it carries poisoned write data.
    assign go_bus      = legal && !((a_opcode != A_GET) && a_corrupt);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));
    assign is_get      = (op_q == A_GET);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        rb_req  = 1'b0;
        d_valid = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                a_ready = 1'b1;
                if (a_valid) begin
                    state_d = go_bus ? BUS : RESP;
                end
            end
            BUS: begin
                rb_req = 1'b1;
                if (rb_ack || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                d_valid = 1'b1;
                if (d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs stay low for the whole time reset is held.
        if (reset) begin
            a_ready = 1'b0;
            rb_req  = 1'b0;
            d_valid = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            size_q   <= '0;
            source_q <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            resp_q   <= '0;
        end else begin
            if ((state_q == IDLE) && a_valid) begin
                op_q          <= a_opcode;
                size_q        <= a_size;
                source_q      <= a_source;
                addr_q        <= a_address;
                mask_q        <= a_mask;
                data_q        <= a_data;
                rdata_q       <= '0;
                cnt_q         <= '0;
                resp_q.opcode <= (a_opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                resp_q.denied <= !go_bus;
            end
            if (state_q == BUS) begin
                if (rb_ack) begin
                    rdata_q       <= rb_rdata;
                    resp_q.denied <= rb_err;
                end else if (timeout_hit) begin
                    rdata_q       <= '0;
                    resp_q.denied <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign rb_we    = rb_req && !is_get;
    assign rb_addr  = rb_req ? (addr_q & WORD_MASK) : '0;
    assign rb_wdata = rb_req ? data_q : '0;
    assign rb_wmask = !rb_req ? '0 : (is_get ? '1 : mask_q);

    assign d_opcode  = d_valid ? resp_q.opcode : '0;
    assign d_param   = '0;
    assign d_size    = d_valid ? size_q : '0;
    assign d_source  = d_valid ? source_q : '0;
    assign d_sink    = 1'b0;
    assign d_denied  = d_valid && resp_q.denied;
    assign d_corrupt = d_valid && resp_q.denied && is_get;
    assign d_data    = (d_valid && is_get && !resp_q.denied) ? rdata_q : '0;

endmodule

// File: tb/tb_tl_ul_regbus_bridge.sv
module tb_tl_ul_regbus_bridge;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [1:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        rb_req;
    logic        rb_we;
    logic [31:0] rb_addr;
    logic [31:0] rb_wdata;
    logic [3:0]  rb_wmask;
    logic        rb_ack;
    logic [31:0] rb_rdata;
    logic        rb_err;
    logic        busy;

    int passed = 0;
    int total  = 0;

    tl_ul_regbus_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .SIZE_W  (2),
        .SRC_W   (2),
        .TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .rb_req    (rb_req),
        .rb_we     (rb_we),
        .rb_addr   (rb_addr),
        .rb_wdata  (rb_wdata),
        .rb_wmask  (rb_wmask),
        .rb_ack    (rb_ack),
        .rb_rdata  (rb_rdata),
        .rb_err    (rb_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [1:0] size, input logic [1:0] src,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic corrupt);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corrupt;
    endtask

    task automatic finish_resp();
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        if ({a_ready, busy, rb_req, d_valid, d_denied} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000", {a_ready, busy, rb_req, d_valid, d_denied});
        else passed++;
        total++;
        reset = 1'b0;
        tick();
        if ({a_ready, busy} !== 2'b10)
            $display("FAIL reset_release_idle: got %b expected 10", {a_ready, busy});
        else passed++;
        total++;
    endtask

    task automatic test_get();
        send_a(3'd4, 2'd2, 2'd1, 32'h10, 4'hF, 32'h0, 1'b0);
        if (a_ready !== 1'b1)
            $display("FAIL get_a_ready: got %b expected 1", a_ready);
        else passed++;
        total++;
        tick();
        a_valid = 1'b0;
        if ({rb_req, rb_we, busy, d_valid} !== 4'b1010)
            $display("FAIL get_bus_ctrl: got %b expected 1010", {rb_req, rb_we, busy, d_valid});
        else passed++;
        total++;
        if ({rb_addr, rb_wmask} !== {32'h10, 4'hF})
            $display("FAIL get_bus_addr: got %h expected %h", {rb_addr, rb_wmask}, {32'h10, 4'hF});
        else passed++;
        total++;
        tick();
        if (rb_req !== 1'b1)
            $display("FAIL get_req_held: got %b expected 1", rb_req);
        else passed++;
        total++;
        tick();
        rb_ack   = 1'b1;
        rb_rdata = 32'hDEADBEEF;
        if (d_valid !== 1'b0)
            $display("FAIL get_no_early_d: got %b expected 0", d_valid);
        else passed++;
        total++;
        tick();
        rb_ack   = 1'b0;
        rb_rdata = 32'h0;
        if ({rb_req, d_valid, d_opcode, d_denied, d_corrupt, d_source, d_size} !== 11'b0_1_001_0_0_01_10)
            $display("FAIL get_d_fields: got %b expected 01001000110",
                     {rb_req, d_valid, d_opcode, d_denied, d_corrupt, d_source, d_size});
        else passed++;
        total++;
        if (d_data !== 32'hDEADBEEF)
            $display("FAIL get_d_data: got %h expected deadbeef", d_data);
        else passed++;
        total++;
        finish_resp();
        if ({d_valid, busy, a_ready} !== 3'b001)
            $display("FAIL get_back_idle: got %b expected 001", {d_valid, busy, a_ready});
        else passed++;
        total++;
    endtask

    task automatic test_put_partial();
        send_a(3'd1, 2'd1, 2'd2, 32'h6, 4'hC, 32'hAABB0000, 1'b0);
        tick();
        a_valid = 1'b0;
        if ({rb_req, rb_we, rb_wmask} !== 6'b11_1100)
            $display("FAIL put_bus_ctrl: got %b expected 111100", {rb_req, rb_we, rb_wmask});
        else passed++;
        total++;
        if ({rb_addr, rb_wdata} !== {32'h4, 32'hAABB0000})
            $display("FAIL put_bus_addr_data: got %h expected %h", {rb_addr, rb_wdata}, {32'h4, 32'hAABB0000});
        else passed++;
        total++;
        rb_ack = 1'b1;
        tick();
        rb_ack = 1'b0;
        if ({d_valid, d_opcode, d_denied, d_corrupt, d_source, d_size} !== 10'b1_000_0_0_10_01)
            $display("FAIL put_d_fields: got %b expected 1000001001",
                     {d_valid, d_opcode, d_denied, d_corrupt, d_source, d_size});
        else passed++;
        total++;
        if (d_data !== 32'h0)
            $display("FAIL put_d_data: got %h expected 0", d_data);
        else passed++;
        total++;
        finish_resp();
    endtask

    task automatic test_illegal();
        // arithmetic opcode, 8-byte Get, misaligned word Get, poisoned PutFull
        logic [2:0]  ops   [4] = '{3'd2, 3'd4, 3'd4, 3'd0};
        logic [1:0]  sizes [4] = '{2'd2, 2'd3, 2'd2, 2'd2};
        logic [31:0] addrs [4] = '{32'h0, 32'h0, 32'h2, 32'h8};
        logic        corr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  exp_d [4] = '{4'b0000, 4'b1001, 4'b1001, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            send_a(ops[i], sizes[i], 2'd3, addrs[i], 4'hF, 32'h12345678, corr[i]);
            tick();
            a_valid = 1'b0;
            if ({rb_req, d_valid, d_denied} !== 3'b011)
                $display("FAIL illegal_%0d_ctrl: got %b expected 011", i, {rb_req, d_valid, d_denied});
            else passed++;
            total++;
            if ({d_corrupt, d_opcode} !== exp_d[i])
                $display("FAIL illegal_%0d_op: got %b expected %b", i, {d_corrupt, d_opcode}, exp_d[i]);
            else passed++;
            total++;
            if (d_data !== 32'h0)
                $display("FAIL illegal_%0d_data: got %h expected 0", i, d_data);
            else passed++;
            total++;
            finish_resp();
        end
    endtask

    task automatic test_byte_get();
        send_a(3'd4, 2'd0, 2'd0, 32'h13, 4'h8, 32'h0, 1'b0);
        tick();
        a_valid = 1'b0;
        if ({rb_req, rb_addr, rb_wmask} !== {1'b1, 32'h10, 4'hF})
            $display("FAIL byte_bus: got %h expected %h", {rb_req, rb_addr, rb_wmask}, {1'b1, 32'h10, 4'hF});
        else passed++;
        total++;
        rb_ack   = 1'b1;
        rb_rdata = 32'h11223344;
        tick();
        rb_ack   = 1'b0;
        if ({d_valid, d_denied, d_data} !== {1'b1, 1'b0, 32'h11223344})
            $display("FAIL byte_resp: got %h expected %h", {d_valid, d_denied, d_data}, {1'b1, 1'b0, 32'h11223344});
        else passed++;
        total++;
        finish_resp();
    endtask

    task automatic test_get_err();
        send_a(3'd4, 2'd2, 2'd3, 32'h20, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid  = 1'b0;
        rb_ack   = 1'b1;
        rb_err   = 1'b1;
        rb_rdata = 32'h12345678;
        tick();
        rb_ack   = 1'b0;
        rb_err   = 1'b0;
        if ({d_valid, d_opcode, d_denied, d_corrupt, d_source} !== 8'b1_001_1_1_11)
            $display("FAIL err_d_fields: got %b expected 10011111",
                     {d_valid, d_opcode, d_denied, d_corrupt, d_source});
        else passed++;
        total++;
        if (d_data !== 32'h0)
            $display("FAIL err_d_data: got %h expected 0", d_data);
        else passed++;
        total++;
        finish_resp();
        // rb_err without rb_ack must not mark the response
        send_a(3'd4, 2'd2, 2'd0, 32'h24, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid = 1'b0;
        rb_err  = 1'b1;
        tick();
        rb_err   = 1'b0;
        rb_ack   = 1'b1;
        rb_rdata = 32'h55AA55AA;
        tick();
        rb_ack   = 1'b0;
        if ({d_valid, d_denied, d_corrupt, d_data} !== {3'b100, 32'h55AA55AA})
            $display("FAIL err_without_ack: got %h expected %h", {d_valid, d_denied, d_corrupt, d_data},
                     {3'b100, 32'h55AA55AA});
        else passed++;
        total++;
        finish_resp();
    endtask

    task automatic test_timeout();
        send_a(3'd4, 2'd2, 2'd0, 32'h30, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if ({rb_req, d_valid} !== 2'b10)
                $display("FAIL timeout_stall_%0d: got %b expected 10", i, {rb_req, d_valid});
            else passed++;
            total++;
            tick();
        end
        if ({rb_req, d_valid, d_denied, d_corrupt, d_opcode} !== 7'b0111_001)
            $display("FAIL timeout_resp: got %b expected 0111001", {rb_req, d_valid, d_denied, d_corrupt, d_opcode});
        else passed++;
        total++;
        rb_ack   = 1'b1;
        rb_rdata = 32'hFFFFFFFF;
        tick();
        rb_ack   = 1'b0;
        if ({d_valid, d_denied, d_data} !== {2'b11, 32'h0})
            $display("FAIL timeout_late_ack_held: got %h expected %h", {d_valid, d_denied, d_data}, {2'b11, 32'h0});
        else passed++;
        total++;
        finish_resp();
        rb_ack = 1'b1;
        tick();
        rb_ack = 1'b0;
        tick();
        if ({d_valid, busy, rb_req, a_ready} !== 4'b0001)
            $display("FAIL timeout_no_second_resp: got %b expected 0001", {d_valid, busy, rb_req, a_ready});
        else passed++;
        total++;
    endtask

    task automatic test_backpressure();
        send_a(3'd4, 2'd2, 2'd2, 32'h40, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid  = 1'b0;
        rb_ack   = 1'b1;
        rb_rdata = 32'h0BADF00D;
        tick();
        rb_ack   = 1'b0;
        rb_rdata = 32'h0;
        send_a(3'd0, 2'd2, 2'd1, 32'h44, 4'hF, 32'hFEEDFACE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if ({d_valid, a_ready, d_opcode, d_source, d_data} !== {2'b10, 3'b001, 2'd2, 32'h0BADF00D})
                $display("FAIL bp_hold_%0d: got %h expected %h", i, {d_valid, a_ready, d_opcode, d_source, d_data},
                         {2'b10, 3'b001, 2'd2, 32'h0BADF00D});
            else passed++;
            total++;
            tick();
        end
        a_valid = 1'b0;
        finish_resp();
        if ({busy, a_ready, d_valid} !== 3'b010)
            $display("FAIL bp_release: got %b expected 010", {busy, a_ready, d_valid});
        else passed++;
        total++;
        tick();
        if ({busy, rb_req} !== 2'b00)
            $display("FAIL bp_no_accept: got %b expected 00", {busy, rb_req});
        else passed++;
        total++;
    endtask

    task automatic test_reset_mid();
        send_a(3'd4, 2'd2, 2'd1, 32'h50, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid = 1'b0;
        reset   = 1'b1;
        tick();
        if ({rb_req, d_valid, a_ready, busy} !== 4'b0000)
            $display("FAIL rst_mid_outputs: got %b expected 0000", {rb_req, d_valid, a_ready, busy});
        else passed++;
        total++;
        reset = 1'b0;
        tick();
        if ({a_ready, busy, d_valid} !== 3'b100)
            $display("FAIL rst_mid_idle: got %b expected 100", {a_ready, busy, d_valid});
        else passed++;
        total++;
        send_a(3'd4, 2'd2, 2'd1, 32'h54, 4'hF, 32'h0, 1'b0);
        tick();
        a_valid = 1'b0;
        if ({rb_req, rb_addr} !== {1'b1, 32'h54})
            $display("FAIL rst_mid_new_req: got %h expected %h", {rb_req, rb_addr}, {1'b1, 32'h54});
        else passed++;
        total++;
        rb_ack   = 1'b1;
        rb_rdata = 32'hCAFEF00D;
        tick();
        rb_ack   = 1'b0;
        if ({d_valid, d_denied, d_source, d_data} !== {2'b10, 2'd1, 32'hCAFEF00D})
            $display("FAIL rst_mid_new_resp: got %h expected %h", {d_valid, d_denied, d_source, d_data},
                     {2'b10, 2'd1, 32'hCAFEF00D});
        else passed++;
        total++;
        finish_resp();
    endtask

    initial begin
        reset     = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        a_corrupt = 1'b0;
        d_ready   = 1'b0;
        rb_ack    = 1'b0;
        rb_rdata  = '0;
        rb_err    = 1'b0;

        test_reset();
        test_get();
        test_put_partial();
        test_illegal();
        test_byte_get();
        test_get_err();
        test_timeout();
        test_backpressure();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
